// File: rtl/mdu_if.sv
`default_nettype none
// ============================================================================
// Module  : mdu_if
// Brief   : Request/result bundle between the pipeline and the iterative MDU.
// Revision: 1.0
// ============================================================================
interface mdu_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, cancel, hi_wr, lo_wr, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, hi_wr, lo_wr, wdata,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module  : mdu_iter
// Brief   : Iterative radix-2 multiply/divide unit owning the HI/LO registers.
// Revision: 1.0
// ============================================================================
module mdu_iter (
  input  wire logic clk,
  input  wire logic rstn,
  mdu_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic        r_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_signed;
  logic        w_bzero;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_sum;
  logic [32:0] w_rem_s;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [63:0] w_step;
  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [63:0] w_fix;

  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.cancel;
  assign w_signed = !bus.op[0];
  // Divide by zero bypasses sign handling so hi ends up holding the raw dividend.
  assign w_bzero  = bus.op[1] && (bus.b == 32'd0);
  assign w_mag_a  = (w_signed && !w_bzero && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
  assign w_mag_b  = (w_signed && !w_bzero && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

  assign w_sum    = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_rem_s  = {r_acc[63:32], r_acc[31]};
  assign w_diff   = w_rem_s - {1'b0, r_opnd};
  assign w_ge     = !w_diff[32];
  assign w_step   = r_div ? {(w_ge ? w_diff[31:0] : w_rem_s[31:0]), r_acc[30:0], w_ge}
                          : {w_sum, r_acc[31:1]};

  assign w_prod   = r_neg_q ? (~r_acc + 64'd1) : r_acc;
  assign w_quot   = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem    = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
  assign w_fix    = r_div ? {w_rem, w_quot} : w_prod;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN: begin
        if (bus.cancel)           w_next = S_IDLE;
        else if (r_cnt == 5'd31)  w_next = S_FIX;
      end
      S_FIX:  w_next = bus.cancel ? S_IDLE : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt   <= 5'd0;
      r_acc   <= 64'd0;
      r_opnd  <= 32'd0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= 5'd0;
            r_div   <= bus.op[1];
            r_neg_q <= w_signed && !w_bzero && (bus.a[31] ^ bus.b[31]);
            r_neg_r <= w_signed && !w_bzero && bus.a[31];
            // Multiply keeps the multiplier in the low half; divide shifts the dividend out of it.
            r_acc   <= bus.op[1] ? {32'd0, w_mag_a} : {32'd0, w_mag_b};
            r_opnd  <= bus.op[1] ? w_mag_b : w_mag_a;
          end else begin
            if (bus.hi_wr) r_hi <= bus.wdata;
            if (bus.lo_wr) r_lo <= bus.wdata;
          end
        end
        S_RUN: begin
          if (!bus.cancel) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_FIX: begin
          if (!bus.cancel) begin
            r_hi <= w_fix[63:32];
            r_lo <= w_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE) && !bus.cancel;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mdu_iter
// Brief   : Directed bench for mdu_iter with a per-cycle reference model.
// Revision: 1.0
// ============================================================================
module tb_mdu_iter;

  logic clk;
  logic rstn;
  mdu_if u_if();

  mdu_iter u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int done_cnt = 0;
  bit chk_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: begin p = sa * sb; return p; end
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Reference: cycles left until idle after an accepted op, plus architectural HI/LO.
  int          m_left = 0;
  logic [31:0] m_hi = 0;
  logic [31:0] m_lo = 0;
  logic [63:0] m_res = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_left = 0; m_hi = 0; m_lo = 0;
    end else if (m_left == 0) begin
      if (u_if.start && !u_if.cancel) begin
        m_res  = model_result(u_if.op, u_if.a, u_if.b);
        m_left = 34;
      end else begin
        if (u_if.hi_wr) m_hi = u_if.wdata;
        if (u_if.lo_wr) m_lo = u_if.wdata;
      end
    end else if (u_if.cancel) begin
      m_left = 0;
    end else begin
      if (m_left == 2) {m_hi, m_lo} = m_res;
      m_left--;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", {31'd0, u_if.busy}, {31'd0, m_left != 0});
      check("model_done", {31'd0, u_if.done}, {31'd0, (m_left == 1) && !u_if.cancel});
      check("model_hi", u_if.hi, m_hi);
      check("model_lo", u_if.lo, m_lo);
    end
    if (u_if.done === 1'b1) done_cnt++;
  end

  task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    u_if.start = 1'b1; u_if.op = op; u_if.a = a; u_if.b = b;
    @(posedge clk); #1;
    u_if.start = 1'b0;
  endtask

  // Counts negedges after the accepting edge; returns cycle of done and busy cycles.
  task automatic wait_idle(output int lat, output int bcnt);
    int n;
    n = 0; lat = -1; bcnt = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (u_if.busy) bcnt++;
      if (u_if.done && lat < 0) lat = n;
      if (!u_if.busy) break;
    end
    if (u_if.busy) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic mt_write(input logic hw, input logic lw, input logic [31:0] d);
    @(posedge clk); #1;
    u_if.hi_wr = hw; u_if.lo_wr = lw; u_if.wdata = d;
    @(posedge clk); #1;
    u_if.hi_wr = 1'b0; u_if.lo_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bc, d0;
    rstn = 1'b0;
    u_if.start = 0; u_if.op = 0; u_if.a = 0; u_if.b = 0;
    u_if.cancel = 0; u_if.hi_wr = 0; u_if.lo_wr = 0; u_if.wdata = 0;
    @(posedge clk); #1; chk_en = 1;
    @(posedge clk); #1; rstn = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, u_if.busy}, 32'd0);
    check("reset_hi", u_if.hi, 32'd0);
    check("reset_lo", u_if.lo, 32'd0);

    // MULT -3 * 5
    do_start(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_idle(lat, bc);
    check("mult_latency", lat, 32'd34);
    check("mult_busy_cycles", bc, 32'd34);
    check("mult_hi", u_if.hi, 32'hFFFF_FFFF);
    check("mult_lo", u_if.lo, 32'hFFFF_FFF1);

    do_start(2'b11, 32'd100, 32'd7);
    wait_idle(lat, bc);
    check("divu_latency", lat, 32'd34);
    check("divu_lo", u_if.lo, 32'd14);
    check("divu_hi", u_if.hi, 32'd2);

    do_start(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_idle(lat, bc);
    check("div_neg_lo", u_if.lo, 32'hFFFF_FFFD);
    check("div_neg_hi", u_if.hi, 32'hFFFF_FFFF);

    do_start(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(lat, bc);
    check("div_ovf_lo", u_if.lo, 32'h8000_0000);
    check("div_ovf_hi", u_if.hi, 32'd0);

    do_start(2'b11, 32'h1234, 32'd0);
    wait_idle(lat, bc);
    check("divz_latency", lat, 32'd34);
    check("divz_lo", u_if.lo, 32'hFFFF_FFFF);
    check("divz_hi", u_if.hi, 32'h1234);

    do_start(2'b10, 32'hFFFF_FFF9, 32'd0);
    wait_idle(lat, bc);
    check("div_signed_z_lo", u_if.lo, 32'hFFFF_FFFF);
    check("div_signed_z_hi", u_if.hi, 32'hFFFF_FFF9);

    mt_write(1'b1, 1'b1, 32'h1357_9BDF);
    @(negedge clk);
    check("mt_both_hi", u_if.hi, 32'h1357_9BDF);
    check("mt_both_lo", u_if.lo, 32'h1357_9BDF);

    // MTHI, then an op cancelled at RUN step 10
    mt_write(1'b1, 1'b0, 32'hA5A5_A5A5);
    d0 = done_cnt;
    do_start(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1 u_if.cancel = 1'b1;
    @(posedge clk); #1 u_if.cancel = 1'b0;
    @(negedge clk);
    check("cancel_busy", {31'd0, u_if.busy}, 32'd0);
    check("cancel_hi", u_if.hi, 32'hA5A5_A5A5);
    check("cancel_lo", u_if.lo, 32'h1357_9BDF);
    check("cancel_no_done", done_cnt, d0);

    do_start(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(lat, bc);
    check("multu_max_hi", u_if.hi, 32'hFFFF_FFFE);
    check("multu_max_lo", u_if.lo, 32'h0000_0001);

    // start while busy is ignored
    do_start(2'b01, 32'd3, 32'd4);
    repeat (5) @(posedge clk);
    #1 u_if.start = 1'b1; u_if.op = 2'b11; u_if.a = 32'd5; u_if.b = 32'd6;
    @(posedge clk); #1 u_if.start = 1'b0;
    wait_idle(lat, bc);
    check("busy_start_lo", u_if.lo, 32'd12);
    check("busy_start_hi", u_if.hi, 32'd0);
    @(negedge clk);
    check("busy_start_idle", {31'd0, u_if.busy}, 32'd0);

    @(posedge clk); #1 u_if.start = 1'b1; u_if.cancel = 1'b1;
    @(posedge clk); #1 u_if.start = 1'b0; u_if.cancel = 1'b0;
    @(negedge clk);
    check("start_cancel_busy", {31'd0, u_if.busy}, 32'd0);

    // reset at RUN step 20, with start/MTHI held during reset
    d0 = done_cnt;
    do_start(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (19) @(posedge clk);
    #1 rstn = 1'b0; u_if.start = 1'b1; u_if.hi_wr = 1'b1; u_if.wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 rstn = 1'b1; u_if.start = 1'b0; u_if.hi_wr = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, u_if.busy}, 32'd0);
    check("rst_hi", u_if.hi, 32'd0);
    check("rst_lo", u_if.lo, 32'd0);
    check("rst_no_done", done_cnt, d0);

    do_start(2'b11, 32'd9, 32'd3);
    wait_idle(lat, bc);
    check("post_rst_lo", u_if.lo, 32'd3);
    check("post_rst_hi", u_if.hi, 32'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
